inv_sqr_stage: RTL and testbench
================================

INV_SQR_STAGE -- requirements
Module: inv_sqr_stage

Interface
REQ-001 The module SHALL have parameter M, default 13, meaning field degree of GF(2^M).
REQ-002 The module SHALL have parameter POLY, default 14'h201B, meaning reduction polynomial x^13+x^4+x^3+x+1 including the x^M term (M+1 bits).
REQ-003 The module SHALL have parameter CW, default 4, meaning width of the squaring-count input.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a new squaring run; sampled only in IDLE.
REQ-007 op_in  input  M  field element to be squared; sampled with start.
REQ-008 count  input  CW  number k of successive squarings (0..2^CW-1); sampled with start.
REQ-009 result  output  M  op_in^(2^k), registered; feeds the inversion-chain register's reg_in.
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle and held afterwards.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, the module SHALL load work<=op_in and cnt<=count, then go to RUN.
REQ-014 In IDLE with start=0, the module SHALL hold all registers.
REQ-015 In RUN with cnt!=0, the module SHALL set work<=sqr(work) and cnt<=cnt-1, staying in RUN.
REQ-016 In RUN with cnt==0, the module SHALL set result<=work and go to DONE.
REQ-017 In DONE, the module SHALL assert done=1 for that cycle and return to IDLE.
REQ-018 Latency from the start-sampling edge to done high SHALL be exactly k+2 cycles; k=0 gives result=op_in after 2 cycles.
REQ-019 start asserted in RUN or DONE SHALL be ignored; there is no queuing.
REQ-020 start asserted in the IDLE cycle directly after DONE SHALL be accepted.
REQ-021 result SHALL change only at the RUN->DONE transition and hold its value otherwise, including in IDLE.
REQ-022 sqr(a) SHALL be the GF(2^M) square: a spread to 2M-1 bits (bit i to bit 2i), reduced modulo POLY; purely combinational, single cycle.
REQ-023 The squaring output SHALL always be fully reduced to M bits; no intermediate width SHALL exceed 2M-1.
REQ-024 The cnt decrement SHALL never wrap: the 0 case exits RUN before any decrement.
REQ-025 busy SHALL be combinationally decoded from the state register (state!=IDLE).

Reset
REQ-026 On rst=0, the module SHALL immediately force state=IDLE, work=0, cnt=0, result=0, done=0, busy=0, regardless of clk.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL accept start normally.
REQ-028 Release of rst SHALL be synchronous to clk by system convention; no additional internal synchronizer.

Structure
REQ-029 M, POLY, CW and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in the shared inversion-generator package.
REQ-030 The squarer SHALL be a separate combinational sub-module gf_sqr (parameters M, POLY), reusable by other ALU stages.
REQ-031 The top level SHALL contain only the FSM, the counter, the work register and the result register.

Verification
REQ-032 Bench: op_in=0x0002, count=1 -> done at start+3 cycles, result=0x0004.
REQ-033 Bench: op_in=0x0080, count=1 -> result=0x0036 (x^14 reduced).
REQ-034 Bench: op_in=0x0002, count=4 -> result=0x00D8 after 6 cycles; start pulsed during RUN is ignored and result is unchanged.
REQ-035 Bench: op_in=0x1ABC, count=0 -> done at start+2 cycles, result=0x1ABC.
REQ-036 Bench: rst low during RUN of count=7 -> outputs 0 and no done pulse; a subsequent op_in=0x0001, count=3 gives result=0x0001.
REQ-037 Bench: 1000 random op_in/count pairs checked against a reference model; back-to-back starts in the IDLE cycle after DONE are accepted.

Source files
------------

// File: rtl/inv_sqr_stage_pkg.sv
// rtl/inv_sqr_stage_pkg.sv - shared inversion-generator constants and FSM encoding
package inv_sqr_stage_pkg;

    localparam int              INV_M    = 13;
    localparam logic [13:0]     INV_POLY = 14'h201B;
    localparam int              INV_CW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inv_sqr_stage_gf_sqr.sv
// rtl/inv_sqr_stage_gf_sqr.sv - combinational GF(2^M) squarer
module gf_sqr #(
    parameter int         M    = 13,
    parameter logic [M:0] POLY = 14'h201B
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    // Polynomial zero-extended to the spread width so shifted copies line up.
    localparam logic [2*M-2:0] POLY_EXT = {{(M-2){1'b0}}, POLY};

    logic [2*M-2:0] t;

    // Spread bit i to bit 2i, then fold the high terms down from the top;
    // each XOR clears bit i because POLY carries the x^M term.
    always_comb begin
        t = '0;
        for (int i = 0; i < M; i++) begin
            t[2*i] = a[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (t[i]) begin
                t = t ^ (POLY_EXT << (i - M));
            end
        end
        y = t[M-1:0];
    end

endmodule

// File: rtl/inv_sqr_stage.sv
// rtl/inv_sqr_stage.sv - repeated-squaring stage computing op_in^(2^k)
module inv_sqr_stage
    import inv_sqr_stage_pkg::*;
#(
    parameter int         M    = INV_M,
    parameter logic [M:0] POLY = INV_POLY,
    parameter int         CW   = INV_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [M-1:0]  op_in,
    input  logic [CW-1:0] count,
    output logic [M-1:0]  result,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [M-1:0]  work;
    logic [M-1:0]  work_sq;
    logic [CW-1:0] cnt;

    gf_sqr #(
        .M    (M),
        .POLY (POLY)
    ) u_sqr (
        .a (work),
        .y (work_sq)
    );

    assign busy = (state != IDLE);

    // Control FSM with the counter, work and result registers; cnt==0 leaves
    // RUN before any decrement so the counter can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= op_in;
                        cnt   <= count;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        result <= work;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        work <= work_sq;
                        cnt  <= cnt - CW'(1);
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sqr_stage.sv
// tb/tb_inv_sqr_stage.sv - self-checking bench for inv_sqr_stage
module tb_inv_sqr_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] op_in;
    logic [3:0]  count;
    logic [12:0] result;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    inv_sqr_stage dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_in  (op_in),
        .count  (count),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Shift-and-add field multiply used as an independent square reference.
    function automatic logic [12:0] ref_mul(input logic [12:0] a, input logic [12:0] b);
        logic [13:0] r;
        r = '0;
        for (int i = 12; i >= 0; i--) begin
            r = r << 1;
            if (r[13]) r = r ^ 14'h201B;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[12:0];
    endfunction

    function automatic logic [12:0] ref_pow(input logic [12:0] a, input logic [3:0] k);
        logic [12:0] r;
        r = a;
        for (int i = 0; i < int'(k); i++) r = ref_mul(r, r);
        return r;
    endfunction

    // Entered and left at a negedge; returns at the negedge where done is high.
    task automatic do_run(input logic [12:0] op, input logic [3:0] k, input logic poke,
                          input string tag, output logic [12:0] got);
        int cyc;
        op_in = op;
        count = k;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_in = 13'h1FFF;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            start = (poke && cyc == 2);
            count = 4'hF;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(int'(k) + 2));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_model"}, 32'(result), 32'(ref_pow(op, k)));
        got = result;
    endtask

    logic [12:0] r;
    logic [12:0] op_r;
    logic [3:0]  k_r;
    int          pulses;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op_in = '0;
        count = '0;
        #2;
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(busy), 32'd0);

        do_run(13'h0002, 4'd1, 1'b0, "x_sq", r);
        check("x_sq_val", 32'(r), 32'h0004);
        @(negedge clk);
        check("x_sq_pulse", 32'(done), 32'd0);
        check("x_sq_idle", 32'(busy), 32'd0);
        check("x_sq_hold", 32'(result), 32'h0004);

        do_run(13'h0080, 4'd1, 1'b0, "x14", r);
        check("x14_val", 32'(r), 32'h0036);
        @(negedge clk);

        do_run(13'h0002, 4'd4, 1'b1, "x16", r);
        check("x16_val", 32'(r), 32'h00D8);
        @(negedge clk);
        @(negedge clk);
        check("x16_noq_busy", 32'(busy), 32'd0);
        check("x16_noq_res", 32'(result), 32'h00D8);

        do_run(13'h1ABC, 4'd0, 1'b0, "k0", r);
        check("k0_val", 32'(r), 32'h1ABC);
        @(negedge clk);

        // Reset in the middle of a long run.
        op_in = 13'h0123;
        count = 4'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("mid_rst_nodone", 32'(pulses), 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);
        do_run(13'h0001, 4'd3, 1'b0, "one", r);
        check("one_val", 32'(r), 32'h0001);

        // Random back-to-back runs, each start in the IDLE cycle after DONE.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            op_r = 13'($urandom);
            k_r  = 4'($urandom_range(0, 15));
            do_run(op_r, k_r, 1'b0, "rnd", r);
        end
        @(negedge clk);
        check("end_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
